// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite master bridge:
// FSM state encoding, AXI response codes, protection default.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both map to a core-visible error.
  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// AXI4-Lite initiator: single-beat load/store port to AXI4-Lite.
// Ports: req_* (core request), rsp_* (core response), m_axi_* (bus).
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                        m_axi_aclk,
  input  logic                        m_axi_areset,

  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,

  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,

  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,

  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,

  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,

  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,

  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  state_t                      r_state;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic                        r_we;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic                        r_awvalid;
  logic                        r_wvalid;
  logic                        r_arvalid;
  logic                        r_bready;
  logic                        r_rready;
  logic                        r_rsp_valid;
  logic                        r_rsp_err;
  logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata;

  logic w_accept;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_aw_all;
  logic w_w_all;

  assign req_ready = (r_state == IDLE) && !m_axi_areset;
  assign w_accept  = req_valid && req_ready;

  assign w_aw_fire = r_awvalid && m_axi_awready;
  assign w_w_fire  = r_wvalid && m_axi_wready;
  // A channel counts as done if it completed earlier or fires now.
  assign w_aw_all  = r_aw_done || w_aw_fire;
  assign w_w_all   = r_w_done || w_w_fire;

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_we        <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            r_we      <= req_we;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (req_addr[1:0] != 2'b00) begin
              // Misaligned: answer locally, bus stays idle.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (req_we) begin
              r_state   <= WADDR_DATA;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= RADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        WADDR_DATA: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_all && w_w_all) begin
            r_state  <= WRESP;
            r_bready <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= resp_is_err(m_axi_bresp);
            r_rsp_rdata <= '0;
            r_state     <= RESP;
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= resp_is_err(m_axi_rresp);
            r_rsp_rdata <= resp_is_err(m_axi_rresp) ?
                           '0 : m_axi_rdata;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_err       = r_rsp_err;
  assign rsp_rdata     = r_rsp_rdata;

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
